// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } loader_state_t;

    localparam int LEN_BYTES = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Boot-link byte stream, instruction-memory write port and core/status lines.
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic       Start;
    logic [7:0] InData;
    logic       InValid;
    logic       InReady;
    logic       ImemWr;
    word_t      ImemWrAddr;
    word_t      ImemWrData;
    logic       CoreHold;
    logic       Done;
    logic       Err;

    modport master (
        output Start, InData, InValid,
        input  InReady, ImemWr, ImemWrAddr, ImemWrData, CoreHold, Done, Err
    );

    modport slave (
        input  Start, InData, InValid,
        output InReady, ImemWr, ImemWrAddr, ImemWrData, CoreHold, Done, Err
    );

endinterface

// File: rtl/imem_loader_word_packer.sv
// Little-endian byte-to-word assembler shared by the length and payload phases.
module word_packer
    import imem_loader_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       shift_en,
    input  logic [7:0] byte_in,
    output word_t      word,
    output logic       WordDone
);

    logic [1:0]  idx_q;
    logic [23:0] shift_q;

    // Only the three previous bytes need storage; the 4th arrives on byte_in.
    assign word     = {byte_in, shift_q};
    assign WordDone = shift_en && (idx_q == 2'(LEN_BYTES - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            idx_q   <= 2'd0;
            shift_q <= 24'd0;
        end else if (shift_en) begin
            idx_q   <= idx_q + 2'd1;
            shift_q <= word[31:8];
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer; holds the core until a load completes.
// Define IMEM_LOADER_CSUM_EN to require a trailing XOR checksum byte.
//
// state | meaning
// IDLE  | after reset, waiting for Start
// LEN   | collecting the 4-byte little-endian word count
// DATA  | collecting payload words, one memory write per word
// CSUM  | comparing the trailing checksum byte (checksum build only)
// DONE  | load complete, core released
// ERR   | load rejected, core held
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int    DEPTH_WORDS = 1024,
    parameter word_t BASE_ADDR   = 32'h0000_0000
)
(
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus
);

    localparam logic [2:0] ST_IDLE = IDLE;
    localparam logic [2:0] ST_LEN  = LEN;
    localparam logic [2:0] ST_DATA = DATA;
    localparam logic [2:0] ST_DONE = DONE;
    localparam logic [2:0] ST_ERR  = ERR;
`ifdef IMEM_LOADER_CSUM_EN
    localparam logic [2:0] ST_CSUM = CSUM;
    localparam logic [2:0] ST_TAIL = ST_CSUM;
`else
    localparam logic [2:0] ST_TAIL = ST_DONE;
`endif
    localparam word_t DEPTH_W = word_t'(DEPTH_WORDS);

    logic [2:0] state_q;
    word_t      addr_q;
    word_t      remain_q;
    logic       wr_q;
    word_t      wr_addr_q;
    word_t      wr_data_q;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0] csum_q;
`endif

    logic  accept;
    logic  restart;
    logic  shift_en;
    word_t word;
    logic  word_done;

    assign bus.InReady = (state_q == ST_LEN) || (state_q == ST_DATA)
`ifdef IMEM_LOADER_CSUM_EN
                         || (state_q == ST_CSUM)
`endif
                         ;
    assign accept   = bus.InValid && bus.InReady;
    assign restart  = bus.Start && ((state_q == ST_IDLE) || (state_q == ST_DONE)
                                    || (state_q == ST_ERR));
    assign shift_en = accept && ((state_q == ST_LEN) || (state_q == ST_DATA));

    word_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .clear    (restart),
        .shift_en (shift_en),
        .byte_in  (bus.InData),
        .word     (word),
        .WordDone (word_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= BASE_ADDR;
            remain_q  <= '0;
            wr_q      <= 1'b0;
            wr_addr_q <= BASE_ADDR;
            wr_data_q <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q    <= 8'd0;
`endif
        end else begin
            wr_q <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
            if (shift_en) begin
                csum_q <= csum_q ^ bus.InData;
            end
`endif
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (bus.Start) begin
                        state_q  <= ST_LEN;
                        addr_q   <= BASE_ADDR;
                        remain_q <= '0;
`ifdef IMEM_LOADER_CSUM_EN
                        csum_q   <= 8'd0;
`endif
                    end
                end
                ST_LEN: begin
                    if (word_done) begin
                        if (word > DEPTH_W) begin
                            state_q <= ST_ERR;
                        end else if (word == '0) begin
                            state_q <= ST_TAIL;
                        end else begin
                            state_q  <= ST_DATA;
                            remain_q <= word;
                        end
                    end
                end
                ST_DATA: begin
                    if (word_done) begin
                        wr_q      <= 1'b1;
                        wr_addr_q <= addr_q;
                        wr_data_q <= word;
                        addr_q    <= addr_q + 32'd4;
                        remain_q  <= remain_q - 32'd1;
                        if (remain_q == 32'd1) begin
                            state_q <= ST_TAIL;
                        end
                    end
                end
`ifdef IMEM_LOADER_CSUM_EN
                ST_CSUM: begin
                    if (accept) begin
                        state_q <= (bus.InData == csum_q) ? ST_DONE : ST_ERR;
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.ImemWr     = wr_q;
    assign bus.ImemWrAddr = wr_addr_q;
    assign bus.ImemWrData = wr_data_q;
    assign bus.CoreHold   = (state_q != ST_DONE);
    assign bus.Done       = (state_q == ST_DONE);
    assign bus.Err        = (state_q == ST_ERR);

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory: accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and drives the instruction memory write port while holding the single-cycle core in reset. It sits between the external boot link and the instruction memory, opposite the core's read-only fetch path. Load completion releases the core, so the first fetch from `BASE_ADDR` sees the freshly written program.

## Interface
- `DEPTH_WORDS`, default 1024: instruction memory capacity in 32-bit words; larger loads are rejected.
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first written word.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `Start` input 1: begin or restart a load; sampled in IDLE, DONE and ERR only.
- `InData` input 8: stream byte.
- `InValid` input 1: `InData` is valid.
- `InReady` output 1: loader accepts a byte this cycle.
- `ImemWr` output 1: one-cycle write strobe to the instruction memory.
- `ImemWrAddr` output 32: byte address of the write, word aligned.
- `ImemWrData` output 32: word to write.
- `CoreHold` output 1: holds the core in reset; ORed with `reset` at the top level.
- `Done` output 1: load completed successfully (level).
- `Err` output 1: load rejected (level).

## Operation
- Transfer occurs when `InValid && InReady`. `InReady` = 1 only in LEN, DATA and CSUM.
- Stream format: 4-byte little-endian word count N, then 4·N payload bytes (little-endian words), then 1 checksum byte if `IMEM_LOADER_CSUM_EN` is defined.
- FSM states:
  - IDLE: waits for `Start`; on `Start`, go to LEN.
  - LEN: collect 4 bytes into N. After the 4th byte: N > `DEPTH_WORDS` → ERR; N = 0 → CSUM, or DONE when checksum is compiled out; otherwise → DATA.
  - DATA: byte index 0..3 fills bits [7:0]..[31:24]. On byte index 3, issue a write, advance the address by 4 and decrement the remaining count. Remaining count reaches 0 → CSUM or DONE.
  - CSUM: accept 1 byte. Match → DONE; mismatch → ERR.
  - DONE: `Done` = 1, `CoreHold` = 0. `Start` → LEN.
  - ERR: `Err` = 1, `CoreHold` = 1. `Start` → LEN.
- Entering LEN clears the byte index, count, checksum accumulator, and `Done`/`Err`, and sets the address to `BASE_ADDR`.
- `Start` in LEN, DATA or CSUM is ignored.
- `CoreHold` = 1 in every state except DONE.
- Address arithmetic is 32-bit unsigned; the `DEPTH_WORDS` check ensures no wrap past `BASE_ADDR + 4·DEPTH_WORDS − 4`.
- Stalls: `InValid` may drop at any byte boundary. State and partial word are held indefinitely, with no timeout.

## Timing
- Reset values: state IDLE, `InReady` 0, `ImemWr` 0, `ImemWrAddr` = `BASE_ADDR`, `ImemWrData` 0, `CoreHold` 1, `Done` 0, `Err` 0.
- Throughput: 1 byte per cycle with `InValid` held high.
- Writes:
  - `ImemWr`, `ImemWrAddr` and `ImemWrData` are registered.
  - Strobe is high exactly 1 cycle, the cycle after the 4th byte of a word is accepted.
  - Address and data are stable during the strobe.
- State transitions take effect the cycle after the triggering transfer. For the final word, `ImemWr` and `Done` (checksum compiled out) rise in the same cycle, together with `CoreHold` falling; the core's first fetch is the following cycle.
- `reset` mid-load aborts immediately: outputs return to reset values next cycle, any partial word is discarded, and memory contents already written are left as is.

## Configuration
- `IMEM_LOADER_CSUM_EN` defined:
  - Running XOR covers all length and payload bytes.
  - A trailing checksum byte is required and compared in CSUM; mismatch → ERR.
- Not defined: CSUM state and accumulator are absent, and the last payload byte (or the 4th length byte when N = 0) goes directly to DONE.

## Structure
- Shared package `imem_loader_pkg`:
  - state enum `loader_state_t` (IDLE, LEN, DATA, CSUM, DONE, ERR);
  - constant `LEN_BYTES` = 4;
  - typedef `word_t` = logic [31:0].
- One sub-module, `word_packer`: byte index counter plus little-endian shift-in. It outputs the assembled word and a `WordDone` pulse, and is shared by LEN (count) and DATA (payload).

## Test plan
- Basic load: reset, `Start`, then N=2 with words 32'h0000_0093, 32'h0010_0113 (checksum compiled out) → writes at 0x0 and 0x4 with those words, `ImemWr` twice, then `Done` = 1 and `CoreHold` = 0 in the cycle of the second write.
- Oversize: N = 1025 with `DEPTH_WORDS` = 1024 → ERR the cycle after the 4th length byte, no `ImemWr`, `InReady` = 0, `CoreHold` = 1.
- Bubbles: same stream as the basic load with `InValid` toggled 1-0-1-0 → identical writes, addresses and data; `ImemWr` only after each 4th accepted byte.
- Checksum (compiled in): N=1, word 32'hDEAD_BEEF, checksum 0x23 → DONE. Checksum 0x24 → ERR; a following `Start` plus a correct stream → DONE.
- Reset mid-word: reset after 2 payload bytes → all outputs at reset values next cycle. A new `Start` plus N=1, 32'h1234_5678 → write 32'h1234_5678 at `BASE_ADDR`.
- N=0 and restart from DONE: N=0 → DONE with no writes. `Start` in DONE → `CoreHold` = 1 and `Done` = 0 next cycle.
